// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and ALU control codes
package cpu_pkg;

    localparam int CPU_DW = 32;
    localparam int CPU_AW = 5;
    localparam int CPU_CW = 4;

    localparam logic [CPU_CW-1:0] ALU_AND  = 4'b0000;
    localparam logic [CPU_CW-1:0] ALU_OR   = 4'b0001;
    localparam logic [CPU_CW-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CPU_CW-1:0] ALU_SLL  = 4'b0101;
    localparam logic [CPU_CW-1:0] ALU_SUB  = 4'b0110;
    localparam logic [CPU_CW-1:0] ALU_SLT  = 4'b0111;
    localparam logic [CPU_CW-1:0] ALU_NOR  = 4'b1100;
    localparam logic [CPU_CW-1:0] ALU_SRLV = 4'b1111;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R1W register file, r0 hardwired zero, write-to-read bypass
module reg_file #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0] regs_q [0:NREGS-1];

    // Array update; address 0 is never written so it stays at its reset zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Reads see a same-cycle write so the consumer never samples a stale value
    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        if (ra1_i == '0) begin
            rd1_o = '0;
        end else if (we_i && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
        if (ra2_i == '0) begin
            rd2_o = '0;
        end else if (we_i && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register read, operand select and ALU input slot
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int AW = CPU_AW,
    parameter int CW = CPU_CW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rt_i,
    input  logic [15:0]   imm_i,
    input  logic          alusrc_i,
    input  logic          sext_i,
    input  logic [CW-1:0] ctrl_i,
    input  logic          flush_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] src1_o,
    output logic [DW-1:0] src2_o,
    output logic [CW-1:0] ctrl_o
);

    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] op2;
    logic          accept;

    logic          valid_q,  valid_d;
    logic [DW-1:0] src1_q,   src1_d;
    logic [DW-1:0] src2_q,   src2_d;
    logic [CW-1:0] ctrl_q,   ctrl_d;
    logic [AW-1:0] rs_q,     rs_d;
    logic [AW-1:0] rt_q,     rt_d;
    logic          alusrc_q, alusrc_d;

    reg_file #(
        .DW (DW),
        .AW (AW)
    ) u_reg_file (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ra1_i (rs_i),
        .ra2_i (rt_i),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (wb_we_i),
        .wa_i  (wb_addr_i),
        .wd_i  (wb_data_i)
    );

    // Immediate extension, operand-2 select and handshake qualification
    always_comb begin
        imm_ext    = {{(DW-16){sext_i & imm_i[15]}}, imm_i};
        op2        = alusrc_i ? imm_ext : rd2;
        in_ready_o = !valid_q || out_ready_i;
        accept     = in_valid_i && in_ready_o && !flush_i;
    end

    // Slot next state: flush beats load, load beats hold, a held slot tracks write-back
    always_comb begin
        valid_d  = valid_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        ctrl_d   = ctrl_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        alusrc_d = alusrc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            src1_d   = rd1;
            src2_d   = op2;
            ctrl_d   = ctrl_i;
            rs_d     = rs_i;
            rt_d     = rt_i;
            alusrc_d = alusrc_i;
        end else if (valid_q && !out_ready_i) begin
            if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rs_q)) begin
                src1_d = wb_data_i;
            end
            if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rt_q) && !alusrc_q) begin
                src2_d = wb_data_i;
            end
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; asynchronous reset drops any in-flight operation
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            ctrl_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            alusrc_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            ctrl_q   <= ctrl_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            alusrc_q <= alusrc_d;
        end
    end

    assign out_valid_o = valid_q;
    assign src1_o      = src1_q;
    assign src2_o      = src2_q;
    assign ctrl_o      = ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        alusrc;
    logic        sext;
    logic [3:0]  ctrl;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl_out;

    int n_vec = 0;
    int n_err = 0;

    operand_fetch dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .rs_i        (rs),
        .rt_i        (rt),
        .imm_i       (imm),
        .alusrc_i    (alusrc),
        .sext_i      (sext),
        .ctrl_i      (ctrl),
        .flush_i     (flush),
        .wb_we_i     (wb_we),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .src1_o      (src1),
        .src2_o      (src2),
        .ctrl_o      (ctrl_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; rs = 0; rt = 0; imm = 0; alusrc = 0; sext = 0; ctrl = 0;
        flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        #12;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (src1 !== 32'h0) begin n_err++; $display("FAIL reset_src1 got %h want 0", src1); end
        n_vec++; if (src2 !== 32'h0) begin n_err++; $display("FAIL reset_src2 got %h want 0", src2); end
        n_vec++; if (ctrl_out !== 4'h0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", ctrl_out); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        tick();
        rst = 0;
        in_valid = 1; rs = 3; rt = 4; alusrc = 0;
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got %b want 1", out_valid); end
        n_vec++; if (src1 !== 32'h0) begin n_err++; $display("FAIL first_src1 got %h want 0", src1); end
        n_vec++; if (src2 !== 32'h0) begin n_err++; $display("FAIL first_src2 got %h want 0", src2); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        in_valid = 1; rs = 5; rt = 0;
        wb_we = 1; wb_addr = 5; wb_data = 32'h0000_1234;
        tick();
        n_vec++; if (src1 !== 32'h0000_1234) begin n_err++; $display("FAIL bypass_rs got %h want 00001234", src1); end
        n_vec++; if (src2 !== 32'h0) begin n_err++; $display("FAIL bypass_rt0 got %h want 0", src2); end
        rs = 0; rt = 5;
        wb_addr = 0; wb_data = 32'hFFFF_FFFF;
        tick();
        n_vec++; if (src1 !== 32'h0) begin n_err++; $display("FAIL r0_bypass got %h want 0", src1); end
        n_vec++; if (src2 !== 32'h0000_1234) begin n_err++; $display("FAIL array_rt got %h want 00001234", src2); end
        wb_we = 0;
        tick();
        n_vec++; if (src1 !== 32'h0) begin n_err++; $display("FAIL r0_after_write got %h want 0", src1); end
    endtask

    task automatic test_immediate();
        idle_inputs();
        in_valid = 1; rs = 5; alusrc = 1; imm = 16'h8001; sext = 1; ctrl = ALU_ADD;
        tick();
        n_vec++; if (src2 !== 32'hFFFF_8001) begin n_err++; $display("FAIL imm_sext got %h want ffff8001", src2); end
        n_vec++; if (ctrl_out !== 4'b0010) begin n_err++; $display("FAIL ctrl_pass got %b want 0010", ctrl_out); end
        n_vec++; if (src1 !== 32'h0000_1234) begin n_err++; $display("FAIL imm_src1 got %h want 00001234", src1); end
        sext = 0; ctrl = ALU_SUB;
        tick();
        n_vec++; if (src2 !== 32'h0000_8001) begin n_err++; $display("FAIL imm_zext got %h want 00008001", src2); end
        n_vec++; if (ctrl_out !== 4'b0110) begin n_err++; $display("FAIL ctrl_sub got %b want 0110", ctrl_out); end
        sext = 1; imm = 16'h7FFF;
        tick();
        n_vec++; if (src2 !== 32'h0000_7FFF) begin n_err++; $display("FAIL imm_sext_pos got %h want 00007fff", src2); end
    endtask

    task automatic test_stall();
        idle_inputs();
        wb_we = 1; wb_addr = 7; wb_data = 32'h1;
        tick();
        wb_addr = 8; wb_data = 32'h2;
        tick();
        wb_we = 0;
        in_valid = 1; rs = 7; rt = 8; alusrc = 0;
        tick();
        n_vec++; if (src1 !== 32'h1 || src2 !== 32'h2) begin n_err++; $display("FAIL stall_load got %h/%h want 1/2", src1, src2); end
        out_ready = 0; rs = 1; rt = 1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_c1 got %b want 0", in_ready); end
        tick();
        wb_we = 1; wb_addr = 8; wb_data = 32'h55;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_c2 got %b want 0", in_ready); end
        tick();
        wb_we = 0;
        n_vec++; if (src2 !== 32'h55) begin n_err++; $display("FAIL stall_wb_src2 got %h want 55", src2); end
        n_vec++; if (src1 !== 32'h1) begin n_err++; $display("FAIL stall_src1 got %h want 1", src1); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_c3 got %b want 0", in_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || src1 !== 32'h1 || src2 !== 32'h55) begin n_err++; $display("FAIL stall_hold got %b %h/%h want 1 1/55", out_valid, src1, src2); end
        out_ready = 1; in_valid = 0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain got %b want 0", out_valid); end
        in_valid = 1; rs = 7; rt = 8; alusrc = 1; imm = 16'h0010; sext = 0;
        tick();
        n_vec++; if (src1 !== 32'h1 || src2 !== 32'h10) begin n_err++; $display("FAIL imm_load got %h/%h want 1/10", src1, src2); end
        out_ready = 0; in_valid = 0;
        wb_we = 1; wb_addr = 8; wb_data = 32'h66;
        tick();
        n_vec++; if (src2 !== 32'h10) begin n_err++; $display("FAIL imm_hold_src2 got %h want 10", src2); end
        wb_addr = 7; wb_data = 32'h77;
        tick();
        wb_we = 0;
        n_vec++; if (src1 !== 32'h77 || src2 !== 32'h10) begin n_err++; $display("FAIL hold_rs_wb got %h/%h want 77/10", src1, src2); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rs_v [4] = '{5'd5, 5'd7, 5'd8, 5'd0};
        logic [31:0] exp1 [4] = '{32'h1234, 32'h77, 32'h66, 32'h0};
        idle_inputs();
        in_valid = 1; alusrc = 1;
        for (int i = 0; i < 4; i++) begin
            rs = rs_v[i]; imm = 16'(i + 1);
            tick();
            n_vec++; if (out_valid !== 1'b1 || src1 !== exp1[i] || src2 !== 32'(i + 1)) begin
                n_err++; $display("FAIL b2b_%0d got %b %h/%h want 1 %h/%h", i, out_valid, src1, src2, exp1[i], i + 1);
            end
        end
    endtask

    task automatic test_flush();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre got %b want 1", out_valid); end
        idle_inputs();
        out_ready = 0;
        flush = 1; in_valid = 1; rs = 5;
        wb_we = 1; wb_addr = 9; wb_data = 32'hA5;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        flush = 0; in_valid = 0; wb_we = 0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped got %b want 0", out_valid); end
        in_valid = 1; rs = 9; rt = 0;
        tick();
        n_vec++; if (out_valid !== 1'b1 || src1 !== 32'hA5) begin n_err++; $display("FAIL flush_wb got %b %h want 1 a5", out_valid, src1); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        in_valid = 1; rs = 5; out_ready = 0;
        tick();
        #2;
        rst = 1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || src1 !== 32'h0) begin n_err++; $display("FAIL async_reset got %b %h want 0 0", out_valid, src1); end
        tick();
        rst = 0;
        out_ready = 1;
        tick();
        n_vec++; if (src1 !== 32'h0) begin n_err++; $display("FAIL reset_clears_rf got %h want 0", src1); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_immediate();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
